branch_predictor: RTL

Fetch-side branch predictor for the pipe-predictor Y86-64 core. It produces the taken/not-taken prediction and predicted PC in F. Its prediction bit travels down the pipeline as E_branch_taken, where pipeline_control compares it with e_Cnd. At execute it resolves the branch, trains a bimodal table of 2-bit saturating counters, and supplies the recovery PC on mispredict.

---
 rtl/branch_predictor_pkg.sv | 32 +++
 rtl/branch_predictor_pattern_history_table.sv | 32 +++
 rtl/branch_predictor.sv | 78 +++++++
 3 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared Y86-64 instruction codes and 2-bit bimodal counter definitions
// for the fetch-side branch predictor.
package branch_predictor_pkg;

  localparam logic [3:0] INOP  = 4'h1;
  localparam logic [3:0] IJXX  = 4'h7;
  localparam logic [3:0] ICALL = 4'h8;
  localparam logic [3:0] IRET  = 4'h9;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } counter_e;

  localparam counter_e PRED_RESET = WT;

  function automatic counter_e sat_next(input counter_e cur, input logic taken);
    counter_e nxt;
    nxt = cur;
    case (cur)
      SNT: nxt = taken ? WNT : SNT;
      WNT: nxt = taken ? WT  : SNT;
      WT:  nxt = taken ? ST  : WNT;
      ST:  nxt = taken ? ST  : WT;
      default: nxt = PRED_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_predictor_pattern_history_table.sv
// Bimodal pattern table: 2**INDEX_BITS saturating counters, one combinational
// read port and one synchronous update port; async reset to weakly taken.
module pattern_history_table
  import branch_predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output counter_e              rd_ctr,
  input  logic                  upd_en,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_taken
);

  localparam int unsigned ENTRIES = 2 ** INDEX_BITS;

  counter_e pht_q [ENTRIES];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) pht_q[i] <= PRED_RESET;
    end else if (upd_en) begin
      pht_q[upd_idx] <= sat_next(pht_q[upd_idx], upd_taken);
    end
  end

  // No bypass: a same-cycle lookup sees the pre-update counter.
  assign rd_ctr = pht_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side predictor: predicts jXX/call in F, resolves and trains at E,
// supplies the recovery PC and keeps saturating branch statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned STAT_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [3:0]            f_icode_i,
  input  logic [3:0]            f_ifun_i,
  input  logic [63:0]           f_pc_i,
  input  logic [63:0]           f_valc_i,
  input  logic [63:0]           f_valp_i,
  output logic                  f_pred_taken_o,
  output logic [63:0]           f_pred_pc_o,
  input  logic [3:0]            E_icode_i,
  input  logic [3:0]            E_ifun_i,
  input  logic [63:0]           E_pc_i,
  input  logic                  E_branch_taken_i,
  input  logic [63:0]           E_valc_i,
  input  logic [63:0]           E_vala_i,
  input  logic                  e_Cnd_i,
  output logic                  e_mispredict_o,
  output logic [63:0]           e_recover_pc_o,
  output logic [STAT_WIDTH-1:0] stat_branches_o,
  output logic [STAT_WIDTH-1:0] stat_mispredicts_o
);

  counter_e rd_ctr;
  logic     e_is_jxx;
  logic     upd_en;
  logic     unused_pc_bits;

  assign unused_pc_bits = ^{f_pc_i[63:INDEX_BITS], E_pc_i[63:INDEX_BITS]};

  pattern_history_table #(
    .INDEX_BITS(INDEX_BITS)
  ) u_pht (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .rd_idx   (f_pc_i[INDEX_BITS-1:0]),
    .rd_ctr   (rd_ctr),
    .upd_en   (upd_en),
    .upd_idx  (E_pc_i[INDEX_BITS-1:0]),
    .upd_taken(e_Cnd_i)
  );

  always_comb begin
    f_pred_taken_o = 1'b0;
    case (f_icode_i)
      IJXX:    f_pred_taken_o = (f_ifun_i == 4'h0) ? 1'b1 : rd_ctr[1];
      ICALL:   f_pred_taken_o = 1'b1;
      IRET:    f_pred_taken_o = 1'b0;
      default: f_pred_taken_o = 1'b0;
    endcase
  end

  assign f_pred_pc_o = f_pred_taken_o ? f_valc_i : f_valp_i;

  assign e_is_jxx       = (E_icode_i == IJXX);
  assign upd_en         = e_is_jxx && (E_ifun_i != 4'h0);
  assign e_mispredict_o = e_is_jxx & (e_Cnd_i ^ E_branch_taken_i);
  assign e_recover_pc_o = (e_is_jxx && e_Cnd_i) ? E_valc_i : E_vala_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stat_branches_o    <= '0;
      stat_mispredicts_o <= '0;
    end else if (upd_en) begin
      if (stat_branches_o != '1) stat_branches_o <= stat_branches_o + 1'b1;
      if (e_mispredict_o && (stat_mispredicts_o != '1))
        stat_mispredicts_o <= stat_mispredicts_o + 1'b1;
    end
  end

endmodule
